// File: rtl/uart_cmd_parser_if.sv
// Byte/handshake bundle between the UART receiver and the command parser.
// Ports: rx_data/rx_valid in; cmd/len/payload and frame/error strobes out.
interface uart_cmd_parser_if #(
    parameter int MAX_LEN = 4
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           cmd;
    logic [2:0]           len;
    logic [8*MAX_LEN-1:0] payload;
    logic                 frame_valid;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;

    modport master (
        output rx_data, rx_valid,
        input  cmd, len, payload,
        input  frame_valid, err_chk, err_len, err_timeout
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd, len, payload,
        output frame_valid, err_chk, err_len, err_timeout
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frame decoder for SYNC,CMD,LEN,PAYLOAD..,CHK command frames from a UART.
// Ports: clk, rst (sync, active high), bus (slave side of uart_cmd_parser_if).
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int          MAX_LEN     = 4,
    parameter int          TIMEOUT_CYC = 104166
) (
    input logic              clk,
    input logic              rst,
    uart_cmd_parser_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        LEN,
        PAYLOAD,
        CHK
    } state_t;

    state_t                     state;
    state_t                     state_n;
    logic                       valid_q;
    logic                       byte_stb;
    logic [7:0]                 cmd_tmp;
    logic [7:0]                 chk;
    logic [2:0]                 len_tmp;
    logic [2:0]                 idx;
    logic [MAX_LEN-1:0][7:0]    buf_q;
    logic [8*MAX_LEN-1:0]       pay_n;
    logic [CW-1:0]              tcnt;
    logic                       tmo;
    logic                       len_bad;
    logic                       do_good;
    logic                       do_chk_err;
    logic                       do_len_err;
    logic                       do_tmo;

    // valid_q resets high so a valid held through reset is not a new byte.
    assign byte_stb = bus.rx_valid & ~valid_q;
    assign len_bad  = bus.rx_data > 8'(MAX_LEN);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo      = (state != HUNT) && !byte_stb &&
                      (tcnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        do_good    = 1'b0;
        do_chk_err = 1'b0;
        do_len_err = 1'b0;
        do_tmo     = 1'b0;
        if (tmo) begin
            state_n = HUNT;
            do_tmo  = 1'b1;
        end else if (byte_stb) begin
            case (state)
                HUNT: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_n = CMD;
                    end
                end
                CMD: begin
                    state_n = LEN;
                end
                LEN: begin
                    if (len_bad) begin
                        do_len_err = 1'b1;
                        state_n    = HUNT;
                    end else if (bus.rx_data[2:0] == 3'd0) begin
                        state_n = CHK;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (idx == len_tmp - 3'd1) begin
                        state_n = CHK;
                    end
                end
                CHK: begin
                    state_n = HUNT;
                    if (bus.rx_data == chk) begin
                        do_good = 1'b1;
                    end else begin
                        do_chk_err = 1'b1;
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    // Stale buffer bytes beyond the frame length are presented as zero.
    always_comb begin
        pay_n = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (3'(i) < len_tmp) begin
                pay_n[8*i +: 8] = buf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= 1'b1;
            cmd_tmp         <= '0;
            chk             <= '0;
            len_tmp         <= '0;
            idx             <= '0;
            buf_q           <= '0;
            tcnt            <= '0;
            bus.cmd         <= '0;
            bus.len         <= '0;
            bus.payload     <= '0;
            bus.frame_valid <= 1'b0;
            bus.err_chk     <= 1'b0;
            bus.err_len     <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            valid_q         <= bus.rx_valid;
            bus.frame_valid <= do_good;
            bus.err_chk     <= do_chk_err;
            bus.err_len     <= do_len_err;
            bus.err_timeout <= do_tmo;

            if (state == HUNT || byte_stb || tmo) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + CW'(1);
            end

            if (byte_stb) begin
                case (state)
                    CMD: begin
                        cmd_tmp <= bus.rx_data;
                        chk     <= bus.rx_data;
                    end
                    LEN: begin
                        if (!len_bad) begin
                            len_tmp <= bus.rx_data[2:0];
                            chk     <= chk ^ bus.rx_data;
                            idx     <= '0;
                        end
                    end
                    PAYLOAD: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx == 3'(i)) begin
                                buf_q[i] <= bus.rx_data;
                            end
                        end
                        chk <= chk ^ bus.rx_data;
                        idx <= idx + 3'd1;
                    end
                    default: begin
                    end
                endcase
            end

            if (do_good) begin
                bus.cmd     <= cmd_tmp;
                bus.len     <= len_tmp;
                bus.payload <= pay_n;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames plus random traffic.
// Expected events come from a byte-queue frame model, checked by a monitor.
module tb_uart_cmd_parser;
    localparam int         ML   = 4;
    localparam int         T    = 50;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct {
        int              kind;
        logic [7:0]      cmd;
        logic [2:0]      len;
        logic [8*ML-1:0] pay;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    uart_cmd_parser_if #(.MAX_LEN(ML)) bus ();

    uart_cmd_parser #(
        .SYNC_BYTE  (SYNC),
        .MAX_LEN    (ML),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int              tests = 0;
    int              fails = 0;
    exp_t            exp_q[$];
    logic [7:0]      frame[$];
    logic [7:0]      m_cmd;
    logic [2:0]      m_len;
    logic [8*ML-1:0] m_pay;

    function automatic void push(int k);
        exp_t e;
        e.kind = k;
        e.cmd  = m_cmd;
        e.len  = m_len;
        e.pay  = m_pay;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        frame.delete();
        m_cmd = '0;
        m_len = '0;
        m_pay = '0;
    endfunction

    // Frame rules applied to the list of bytes collected since SYNC.
    function automatic void model_byte(logic [7:0] b);
        logic [7:0] x;
        logic [7:0] lb;
        int         n;
        if (frame.size() == 0) begin
            if (b == SYNC) frame.push_back(b);
            return;
        end
        frame.push_back(b);
        n = frame.size();
        if (n == 3 && frame[2] > 8'(ML)) begin
            push(2);
            frame.delete();
            return;
        end
        if (n >= 4) begin
            lb = frame[2];
            if (n == 4 + int'(lb)) begin
                x = 8'h00;
                for (int i = 1; i < n - 1; i++) x ^= frame[i];
                if (x == frame[n-1]) begin
                    m_cmd = frame[1];
                    m_len = lb[2:0];
                    m_pay = '0;
                    for (int i = 0; i < int'(lb); i++)
                        m_pay[8*i +: 8] = frame[3+i];
                    push(0);
                end else begin
                    push(1);
                end
                frame.delete();
            end
        end
    endfunction

    // Silence longer than T clocks inside a frame drops it.
    function automatic void model_gap(int cycles);
        if (frame.size() != 0 && cycles > T) begin
            push(3);
            frame.delete();
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte strobe lands h+g clocks before the next byte's strobe.
    task automatic send(input logic [7:0] b, input int h, input int g);
        model_byte(b);
        model_gap(h + g);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        repeat (h) @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input int n,
                              input logic [31:0] p, input bit good);
        logic [7:0] x;
        x = c ^ 8'(n);
        send(SYNC, 1, 2);
        send(c, 1, 2);
        send(8'(n), 2, 1);
        for (int i = 0; i < n; i++) begin
            x ^= p[8*i +: 8];
            send(p[8*i +: 8], 1, 2);
        end
        if (!good) x = ~x;
        send(x, 1, 3);
    endtask

    task automatic rand_frame();
        logic [7:0] bq[$];
        logic [7:0] c;
        logic [7:0] x;
        logic [7:0] b;
        int         k;
        int         n;
        int         h;
        int         g;
        int         longat;
        k = $urandom_range(0, 9);
        if (k == 8) repeat ($urandom_range(1, 3)) bq.push_back(8'($urandom));
        if (k == 7) begin
            bq.push_back(SYNC);
            bq.push_back(8'($urandom));
            bq.push_back(8'($urandom_range(ML + 1, 255)));
        end else begin
            n = $urandom_range(0, ML);
            c = 8'($urandom);
            x = c ^ 8'(n);
            bq.push_back(SYNC);
            bq.push_back(c);
            bq.push_back(8'(n));
            for (int i = 0; i < n; i++) begin
                b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
                x ^= b;
                bq.push_back(b);
            end
            if (k == 6) x ^= 8'($urandom_range(1, 255));
            bq.push_back(x);
        end
        longat = (k == 9) ? $urandom_range(0, bq.size() - 2) : -1;
        foreach (bq[i]) begin
            h = $urandom_range(1, 3);
            g = $urandom_range(1, 4);
            if (i == longat) g = T - h + $urandom_range(1, 3);
            else if ($urandom_range(0, 19) == 0) g = T - h;
            send(bq[i], h, g);
        end
    endtask

    // Monitor: every strobe cycle is matched against the next expected event.
    initial begin
        int   nstb;
        int   kind;
        exp_t e;
        forever begin
            @(negedge clk);
            nstb = int'(bus.frame_valid === 1'b1) + int'(bus.err_chk === 1'b1) +
                   int'(bus.err_len === 1'b1) + int'(bus.err_timeout === 1'b1);
            if (nstb != 0) begin
                kind = (bus.frame_valid === 1'b1) ? 0 :
                       (bus.err_chk === 1'b1) ? 1 :
                       (bus.err_len === 1'b1) ? 2 : 3;
                if (nstb > 1) begin
                    tests++;
                    fails++;
                    $display("FAIL strobes: got %0d high expected 1", nstb);
                end else if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected: got kind %0d expected none", kind);
                end else begin
                    e = exp_q.pop_front();
                    check("kind", 64'(kind), 64'(e.kind));
                    check("cmd", 64'(bus.cmd), 64'(e.cmd));
                    check("len", 64'(bus.len), 64'(e.len));
                    check("payload", 64'(bus.payload), 64'(e.pay));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_cmd", 64'(bus.cmd), 64'h0);
        check("rst_len", 64'(bus.len), 64'h0);
        check("rst_pay", 64'(bus.payload), 64'h0);
        check("rst_stb", 64'({bus.frame_valid, bus.err_chk,
                              bus.err_len, bus.err_timeout}), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        send(SYNC, 1, 2); send(8'h10, 1, 2); send(8'h02, 1, 2);
        send(8'h33, 1, 2); send(8'h44, 1, 2); send(8'h65, 1, 3);
        check("good_pay", 64'(bus.payload), 64'h4433);

        send(SYNC, 1, 2); send(8'h10, 1, 2); send(8'h02, 1, 2);
        send(8'h33, 1, 2); send(8'h44, 1, 2); send(8'h00, 1, 3);
        check("badchk_hold", 64'(bus.payload), 64'h4433);

        send(SYNC, 1, 2); send(8'h20, 1, 2); send(8'h05, 1, 3);
        send(SYNC, 1, 2); send(8'h01, 1, 2); send(8'h00, 1, 2);
        send(8'h01, 1, 3);

        send(SYNC, 1, 2); send(8'h10, 1, T);
        send(8'h10, 1, 2);
        send_frame(8'h22, 3, 32'h00CC_BBAA, 1'b1);

        send(SYNC, 1, 2); send(8'h33, 1, T - 1); send(8'h01, 1, 2);
        send(8'h7E, 1, 2); send(8'h33 ^ 8'h01 ^ 8'h7E, 1, 3);

        send(8'h00, 1, 2); send(8'hFF, 1, 2); send(8'h5A, 1, 2);
        send_frame(8'h07, 3, 32'h00A5_12A5, 1'b1);
        check("embed_pay", 64'(bus.payload), 64'hA512A5);

        bus.rx_data  = SYNC;
        bus.rx_valid = 1'b1;
        rst          = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("hold_cmd", 64'(bus.cmd), 64'h0);
        send(8'h10, 1, 2); send(8'h02, 1, 2); send(8'h33, 1, 2);
        send(8'h44, 1, 2); send(8'h65, 1, 3);
        send_frame(8'h44, 4, 32'h0403_0201, 1'b1);

        send(SYNC, 1, 2); send(8'h10, 1, 2); send(8'h02, 1, 2);
        send(8'h33, 1, 2);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("midrst_cmd", 64'(bus.cmd), 64'h0);
        check("midrst_pay", 64'(bus.payload), 64'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h55, 1, 32'h0000_00A5, 1'b1);
        send_frame(8'h56, 2, 32'h0000_1234, 1'b0);

        repeat (150) rand_frame();

        model_gap(1 << 30);
        repeat (T + 20) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
